// File: rtl/q_select_max.sv
// rtl/q_select_max.sv - handshaked Q-row word selector / argmax scanner
//
// Purpose: takes one flattened Q-row of NUM_CH action values. Mode 0 returns
// the word at index sel (latency 1); mode 1 scans the row one channel per cycle
// and returns the maximum value and its lowest index (latency NUM_CH).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   mode, sel, din      request: 0 = indexed select, 1 = argmax; index; row
//   out_valid/out_ready result handshake
//   dout, dout_idx, err result word, its channel index, out-of-range flag

module q_select_max #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 16,
  parameter int SIGNED = 1,
  localparam int IDX_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic [IDX_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        dout,
  output logic [IDX_W-1:0]         dout_idx,
  output logic                     err
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]  row_q, row_d;
  logic [DATA_W-1:0]         best_q, best_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]         dout_q, dout_d;
  logic [IDX_W-1:0]          dout_idx_q, dout_idx_d;
  logic                      err_q, err_d;

  logic [DATA_W-1:0]         sel_word;
  logic [DATA_W-1:0]         scan_word;
  logic                      sel_in_range;
  logic                      scan_gt;

  // Explicit mux loops so an out-of-range sel (non power-of-2 NUM_CH) never
  // indexes past the row; it simply yields zero.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) sel_word = din[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    scan_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(cnt_q) == k) scan_word = row_q[k*DATA_W +: DATA_W];
    end
  end

  assign sel_in_range = (int'(sel) < NUM_CH);

  // Strictly greater: ties keep the earlier (lower) index.
  assign scan_gt = (SIGNED != 0) ? ($signed(scan_word) > $signed(best_q))
                                 : (scan_word > best_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    dout_idx_d = dout_idx_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          row_d = din;
          if (!mode) begin
            state_d = S_OUT;
            if (sel_in_range) begin
              dout_d     = sel_word;
              dout_idx_d = sel;
              err_d      = 1'b0;
            end else begin
              dout_d     = '0;
              dout_idx_d = '0;
              err_d      = 1'b1;
            end
          end else begin
            best_d     = din[DATA_W-1:0];
            best_idx_d = '0;
            cnt_d      = IDX_W'(1);
            state_d    = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        if (scan_gt) begin
          best_d     = scan_word;
          best_idx_d = cnt_q;
        end
        // Result is taken straight from this cycle's comparison so OUT is
        // reached exactly NUM_CH cycles after the accept.
        if (cnt_q == IDX_W'(NUM_CH-1)) begin
          state_d    = S_OUT;
          dout_d     = scan_gt ? scan_word : best_q;
          dout_idx_d = scan_gt ? cnt_q : best_idx_q;
          err_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      dout_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      dout_idx_q <= dout_idx_d;
      err_q      <= err_d;
    end
  end

  assign dout     = dout_q;
  assign dout_idx = dout_idx_q;
  assign err      = err_q;

endmodule

// File: tb/tb_q_select_max.sv
// tb/tb_q_select_max.sv - self-checking bench for q_select_max

module tb_q_select_max;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [3:0]   sel;
  logic [255:0] din;

  logic         iv16, or16;
  logic         ir16s, ov16s, es16s, ir16u, ov16u, es16u;
  logic [15:0]  d16s, d16u;
  logic [3:0]   x16s, x16u;

  logic         iv12, or12, ir12, ov12, e12;
  logic [15:0]  d12;
  logic [3:0]   x12;

  int total = 0;
  int bad   = 0;

  q_select_max #(.NUM_CH(16), .DATA_W(16), .SIGNED(1)) u16s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16s), .mode(mode),
    .sel(sel), .din(din), .out_valid(ov16s), .out_ready(or16), .dout(d16s),
    .dout_idx(x16s), .err(es16s));

  q_select_max #(.NUM_CH(16), .DATA_W(16), .SIGNED(0)) u16u (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16u), .mode(mode),
    .sel(sel), .din(din), .out_valid(ov16u), .out_ready(or16), .dout(d16u),
    .dout_idx(x16u), .err(es16u));

  q_select_max #(.NUM_CH(12), .DATA_W(16), .SIGNED(1)) u12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(ir12), .mode(mode),
    .sel(sel), .din(din[191:0]), .out_valid(ov12), .out_ready(or12), .dout(d12),
    .dout_idx(x12), .err(e12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int val(input logic [15:0] x, input bit sg);
    if (sg) return int'($signed(x));
    return int'({16'h0, x});
  endfunction

  // Reference: plain indexed read, or a linear max search keeping the first maximum.
  task automatic model(input logic [255:0] d, input int n, input logic m, input int s,
                       input bit sg, output logic [15:0] w, output logic [3:0] ix,
                       output logic e);
    int bi;
    if (!m) begin
      if (s >= n) begin w = 16'h0; ix = 4'h0; e = 1'b1; end
      else begin w = d[s*16 +: 16]; ix = 4'(s); e = 1'b0; end
    end else begin
      bi = 0;
      for (int i = 1; i < n; i++)
        if (val(d[i*16 +: 16], sg) > val(d[bi*16 +: 16], sg)) bi = i;
      w = d[bi*16 +: 16]; ix = 4'(bi); e = 1'b0;
    end
  endtask

  function automatic logic [255:0] rand_row();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 4))
        0: r[i*16 +: 16] = 16'h8000;
        1: r[i*16 +: 16] = 16'h7FFF;
        2: r[i*16 +: 16] = 16'h0000;
        default: r[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_req16(input logic m, input logic [3:0] s, input logic [255:0] d, input int hold);
    logic [15:0] ws, wu;
    logic [3:0]  is_, iu;
    logic        es, eu;
    int          lat;
    model(d, 16, m, int'(s), 1'b1, ws, is_, es);
    model(d, 16, m, int'(s), 1'b0, wu, iu, eu);
    chk("in_ready_idle", {31'h0, ir16s}, 32'h1);
    mode = m; sel = s; din = d; iv16 = 1'b1; or16 = 1'b0;
    tick();
    iv16 = 1'b0; din = rand_row(); sel = 4'($urandom); mode = 1'($urandom);
    lat = 1;
    while (!ov16s && lat < 40) begin
      tick();
      lat++;
      din = rand_row(); sel = 4'($urandom);
    end
    chk("latency", lat, m ? 32'd16 : 32'd1);
    chk("out_valid_u", {31'h0, ov16u}, 32'h1);
    chk("dout_s", {16'h0, d16s}, {16'h0, ws});
    chk("idx_s", {28'h0, x16s}, {28'h0, is_});
    chk("err_s", {31'h0, es16s}, {31'h0, es});
    chk("dout_u", {16'h0, d16u}, {16'h0, wu});
    chk("idx_u", {28'h0, x16u}, {28'h0, iu});
    chk("in_ready_out", {31'h0, ir16s}, 32'h0);
    for (int c = 0; c < hold; c++) begin
      iv16 = 1'b1; mode = 1'($urandom); din = rand_row(); sel = 4'($urandom);
      tick();
      chk("bp_valid", {31'h0, ov16s}, 32'h1);
      chk("bp_dout", {16'h0, d16s}, {16'h0, ws});
      chk("bp_idx", {28'h0, x16s}, {28'h0, is_});
      chk("bp_in_ready", {31'h0, ir16s}, 32'h0);
    end
    iv16 = 1'b0; or16 = 1'b1;
    tick();
    or16 = 1'b0;
    chk("post_valid", {31'h0, ov16s}, 32'h0);
    chk("post_in_ready", {31'h0, ir16s}, 32'h1);
    chk("post_valid_u", {31'h0, ov16u}, 32'h0);
  endtask

  task automatic do_req12(input logic m, input logic [3:0] s, input logic [255:0] d);
    logic [15:0] w;
    logic [3:0]  ix;
    logic        e;
    int          lat;
    model(d, 12, m, int'(s), 1'b1, w, ix, e);
    mode = m; sel = s; din = d; iv12 = 1'b1; or12 = 1'b0;
    tick();
    iv12 = 1'b0; din = rand_row(); sel = 4'($urandom);
    lat = 1;
    while (!ov12 && lat < 40) begin tick(); lat++; end
    chk("latency12", lat, m ? 32'd12 : 32'd1);
    chk("dout12", {16'h0, d12}, {16'h0, w});
    chk("idx12", {28'h0, x12}, {28'h0, ix});
    chk("err12", {31'h0, e12}, {31'h0, e});
    or12 = 1'b1;
    tick();
    or12 = 1'b0;
    chk("post_valid12", {31'h0, ov12}, 32'h0);
  endtask

  logic [255:0] row;
  int           seen_valid;

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 4'h0; din = '0;
    iv16 = 1'b0; or16 = 1'b0; iv12 = 1'b0; or12 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'h0, ir16s}, 32'h1);
    chk("rst_out_valid", {31'h0, ov16s}, 32'h0);
    chk("rst_dout", {16'h0, d16s}, 32'h0);
    chk("rst_idx", {28'h0, x16s}, 32'h0);
    chk("rst_err", {31'h0, es16s}, 32'h0);
    chk("rst_in_ready12", {31'h0, ir12}, 32'h1);

    // Indexed select, ch k = 0x0100+k.
    for (int k = 0; k < 16; k++) row[k*16 +: 16] = 16'h0100 + 16'(k);
    do_req16(1'b0, 4'd5, row, 0);

    // Signed argmax with negative background.
    for (int k = 0; k < 16; k++) row[k*16 +: 16] = 16'hFFF0;
    row[9*16 +: 16] = 16'h0003;
    row[12*16 +: 16] = 16'h8000;
    do_req16(1'b1, 4'd0, row, 0);

    // Ties keep lowest index; then an unsigned-only winner.
    row = '0;
    row[3*16 +: 16] = 16'h7FFF;
    row[11*16 +: 16] = 16'h7FFF;
    do_req16(1'b1, 4'd0, row, 0);
    row[7*16 +: 16] = 16'h8000;
    do_req16(1'b1, 4'd0, row, 0);

    // Backpressure with toggling inputs.
    do_req16(1'b0, 4'($urandom), rand_row(), 5);
    do_req16(1'b1, 4'($urandom), rand_row(), 5);

    // Random mix.
    for (int t = 0; t < 20; t++)
      do_req16(1'($urandom), 4'($urandom), rand_row(), $urandom_range(0, 3));

    // Non power-of-2 row.
    do_req12(1'b0, 4'd13, rand_row());
    do_req12(1'b0, 4'd11, rand_row());
    do_req12(1'b0, 4'd12, rand_row());
    for (int t = 0; t < 3; t++) do_req12(1'b1, 4'd0, rand_row());

    // Reset in the middle of a scan.
    mode = 1'b1; din = rand_row(); iv16 = 1'b1;
    tick();
    iv16 = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, ov16s}, 32'h0);
    chk("mid_rst_dout", {16'h0, d16s}, 32'h0);
    chk("mid_rst_idx", {28'h0, x16s}, 32'h0);
    chk("mid_rst_err", {31'h0, es16s}, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ov16s || ov16u) seen_valid++;
    end
    chk("no_valid_after_rst", seen_valid, 32'h0);
    do_req16(1'b1, 4'd0, rand_row(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
